// File: rtl/wb_uart_pkg.sv
// Shared types and constants for the Wishbone UART transmitter.
package wb_uart_pkg;

    // Shifter sequence: one state per kind of bit on the line.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Bit positions inside the status word returned on a read.
    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_HOLD_FULL = 1;

endpackage

// File: rtl/wb_edge_detect.sv
// Rising-edge detector: registers its input and emits a one-cycle pulse
// whenever the input is high now but was low on the previous clock.
module wb_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // Remember the previous sample of the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/wb_uart.sv
// Wishbone classic slave UART transmitter (8N1 by default).
// A write loads the one-entry holding register; the shifter drains it on a
// bit tick derived from the rising edges of baud_clk_i.
//
// Handshake: a request is valid when wb_cyc_i & wb_stb_i are high and no ack
// is currently out. Reads are always ready. A write is ready when the holding
// register is empty or is being drained on this same clock; otherwise the
// master sees wait states. Accepted requests get wb_ack_o for exactly one cycle.
module wb_uart_tx
    import wb_uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    input  logic       baud_clk_i,
    output logic       tx_o,
    output logic       busy_o
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state, state_next;
    logic [DATA_BITS-1:0] hold, shift, shift_next;
    logic [2:0]           cnt, cnt_next;
    logic                 hold_full;
    logic                 tx, tx_next;
    logic                 tick, drain;
    logic                 rd_req, wr_req, accept;
    logic [7:0]           status;

    wb_edge_detect u_baud_edge (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .d     (baud_clk_i),
        .pulse (tick)
    );

    assign rd_req = wb_cyc_i & wb_stb_i & ~wb_we_i & ~wb_ack_o;
    assign wr_req = wb_cyc_i & wb_stb_i &  wb_we_i & ~wb_ack_o;
    // A write may land in the same cycle the shifter takes the old byte.
    assign accept = wr_req & (~hold_full | drain);

    assign busy_o = (state != IDLE);
    assign tx_o   = tx;

    // Assemble the status word from the live flags.
    always_comb begin
        status                   = 8'h00;
        status[STATUS_BUSY]      = busy_o;
        status[STATUS_HOLD_FULL] = hold_full;
    end

    // Shifter state and line registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            tx    <= 1'b1;
            shift <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            tx    <= tx_next;
            shift <= shift_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: everything advances only on a bit tick.
    always_comb begin
        state_next = state;
        tx_next    = tx;
        shift_next = shift;
        cnt_next   = cnt;
        drain      = 1'b0;
        if (tick) begin
            case (state)
                IDLE, STOP: begin
                    if (hold_full) begin
                        tx_next    = 1'b0;
                        shift_next = hold;
                        cnt_next   = '0;
                        drain      = 1'b1;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end
                START: begin
                    tx_next    = shift[0];
                    shift_next = shift >> 1;
                    state_next = DATA;
                end
                DATA: begin
                    if (cnt == LAST_BIT) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        tx_next    = shift[0];
                        shift_next = shift >> 1;
                        cnt_next   = cnt + 3'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Bus side: acknowledge, read data capture and the holding register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= 8'h00;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            wb_ack_o <= rd_req | accept;
            wb_dat_o <= rd_req ? status : 8'h00;
            if (accept) begin
                hold      <= wb_dat_i[DATA_BITS-1:0];
                hold_full <= 1'b1;
            end else if (drain) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: an 8-bit and a 5-bit instance share the bus
// and baud inputs; each has its own cycle line.
module tb_wb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc8 = 1'b0, cyc5 = 1'b0, stb = 1'b0, we = 1'b0;
    logic [7:0] dat_i = 8'h00;
    logic       baud = 1'b0;
    bit         baud_run = 1'b1;
    logic [7:0] dat8, dat5;
    logic       ack8, ack5, tx8, tx5, busy8, busy5;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         sel;
        logic [7:0] dat;
        int         nbits;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    wb_uart_tx #(.DATA_BITS(8)) dut8 (
        .wb_clk_i (clk), .wb_rst_ni (rst_n), .wb_cyc_i (cyc8), .wb_stb_i (stb),
        .wb_we_i (we), .wb_dat_i (dat_i), .wb_dat_o (dat8), .wb_ack_o (ack8),
        .baud_clk_i (baud), .tx_o (tx8), .busy_o (busy8)
    );

    wb_uart_tx #(.DATA_BITS(5)) dut5 (
        .wb_clk_i (clk), .wb_rst_ni (rst_n), .wb_cyc_i (cyc5), .wb_stb_i (stb),
        .wb_we_i (we), .wb_dat_i (dat_i), .wb_dat_o (dat5), .wb_ack_o (ack5),
        .baud_clk_i (baud), .tx_o (tx5), .busy_o (busy5)
    );

    // Clock and baud reference (16 clocks per bit while running, held low otherwise).
    always #5 clk = ~clk;

    initial begin
        int bcnt;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (baud_run) begin
                bcnt++;
                if (bcnt == 8) begin
                    baud = ~baud;
                    bcnt = 0;
                end
            end else begin
                baud = 1'b0;
                bcnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic get_tx(input bit sel);
        return sel ? tx5 : tx8;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy5 : busy8;
    endfunction

    function automatic logic get_ack(input bit sel);
        return sel ? ack5 : ack8;
    endfunction

    task automatic wb_write(input bit sel, input logic [7:0] d, output int waited);
        @(negedge clk);
        cyc8 = !sel; cyc5 = sel; stb = 1'b1; we = 1'b1; dat_i = d;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (get_ack(sel) !== 1'b1 && waited < 400);
        check("write_ack", get_ack(sel), 1'b1);
        @(negedge clk);
        cyc8 = 1'b0; cyc5 = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input bit sel, output logic [7:0] d);
        int waited;
        @(negedge clk);
        cyc8 = !sel; cyc5 = sel; stb = 1'b1; we = 1'b0;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (get_ack(sel) !== 1'b1 && waited < 20);
        check("read_ack", get_ack(sel), 1'b1);
        d = sel ? dat5 : dat8;
        @(negedge clk);
        cyc8 = 1'b0; cyc5 = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_tx_fall(input bit sel, output int waited);
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (get_tx(sel) !== 1'b0 && waited < 1000);
        check("tx_start", get_tx(sel), 1'b0);
    endtask

    // Called right after the start bit appears; samples mid-bit for n bits.
    task automatic sample_bits(input bit sel, input int n, output logic [39:0] got);
        got = '0;
        repeat (8) @(posedge clk);
        #1;
        got[0] = get_tx(sel);
        for (int k = 1; k < n; k++) begin
            repeat (16) @(posedge clk);
            #1;
            got[k] = get_tx(sel);
        end
    endtask

    // Called at mid stop bit; busy must hold until the tick that ends it.
    task automatic check_busy_fall(input bit sel);
        repeat (7) @(posedge clk);
        #1;
        check("busy_before_stop_end", get_busy(sel), 1'b1);
        @(posedge clk); #1;
        check("busy_after_stop_end", get_busy(sel), 1'b0);
    endtask

    initial begin
        int          w, w1, w2, w3, w4, low_seen;
        logic [7:0]  st;
        logic [39:0] got, got3;

        vecs[0] = '{1'b0, 8'hA5, 10, 10'b1_10100101_0};
        vecs[1] = '{1'b0, 8'h00, 10, 10'b1_00000000_0};
        vecs[2] = '{1'b0, 8'hFF, 10, 10'b1_11111111_0};
        vecs[3] = '{1'b1, 8'hFF, 7,  10'b000_1_11111_0};
        vecs[4] = '{1'b1, 8'hEA, 7,  10'b000_1_01010_0};

        // Reset values.
        #12;
        check("rst_tx8", tx8, 1'b1);
        check("rst_busy8", busy8, 1'b0);
        check("rst_ack8", ack8, 1'b0);
        check("rst_dat8", dat8, 8'h00);
        check("rst_tx5", tx5, 1'b1);
        check("rst_busy5", busy5, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single frames from the vector table.
        for (int i = 0; i < 5; i++) begin
            wb_write(vecs[i].sel, vecs[i].dat, w);
            check("write_latency", w, 1);
            wait_tx_fall(vecs[i].sel, w);
            sample_bits(vecs[i].sel, vecs[i].nbits, got);
            check("frame", {22'b0, got[9:0]}, {22'b0, vecs[i].frame});
            check_busy_fall(vecs[i].sel);
            wb_read(vecs[i].sel, st);
            check("status_idle", st, 8'h00);
        end

        // Back-to-back frames with a stalled third write.
        wb_write(1'b0, 8'h55, w);
        check("b2b_first_latency", w, 1);
        fork
            begin
                wait_tx_fall(1'b0, w1);
                sample_bits(1'b0, 30, got3);
            end
            begin
                wait_tx_fall(1'b0, w2);
                wb_write(1'b0, 8'h0F, w3);
                check("b2b_second_latency", w3, 1);
                wb_read(1'b0, st);
                check("status_busy_hold", st, 8'h03);
                wb_write(1'b0, 8'hFF, w4);
                check("third_write_stalled", (w4 > 100), 1'b1);
                check("third_ack_at_start_bit", tx8, 1'b0);
            end
        join
        check("b2b_frames", {2'b0, got3[29:0]},
              {2'b0, 10'b1_11111111_0, 10'b1_00001111_0, 10'b1_01010101_0});
        check_busy_fall(1'b0);
        wb_read(1'b0, st);
        check("status_after_b2b", st, 8'h00);

        // Stalled baud reference.
        @(posedge clk); #1;
        baud_run = 1'b0;
        repeat (4) @(posedge clk);
        wb_write(1'b0, 8'h3C, w);
        check("stall_write_latency", w, 1);
        repeat (100) @(posedge clk);
        #1;
        check("stall_tx_idle", tx8, 1'b1);
        wb_read(1'b0, st);
        check("stall_status", st, 8'h02);
        repeat (60) @(posedge clk);
        wb_read(1'b0, st);
        check("stall_status_later", st, 8'h02);
        @(posedge clk); #1;
        baud_run = 1'b1;
        wait_tx_fall(1'b0, w);
        check("start_on_first_edge", w, 8);
        sample_bits(1'b0, 10, got);
        check("stall_frame", {22'b0, got[9:0]}, {22'b0, 10'b1_00111100_0});
        check_busy_fall(1'b0);

        // Reset in the middle of a frame with a byte waiting.
        wb_write(1'b0, 8'hA5, w);
        wait_tx_fall(1'b0, w);
        wb_write(1'b0, 8'h81, w);
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx8, 1'b1);
        check("midrst_busy", busy8, 1'b0);
        check("midrst_ack", ack8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_read(1'b0, st);
        check("midrst_status", st, 8'h00);
        low_seen = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (tx8 !== 1'b1) low_seen++;
        end
        check("midrst_no_tx", low_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
